// File: rtl/wb_cal_ctrl_pkg.sv
// rtl/wb_cal_ctrl_pkg.sv - shared mode/state encodings and unity coefficient for the white-balance calibrator
package wb_cal_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'd0,
        MODE_AUTO    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_BYPASS  = 2'd3
    } cal_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_ACCUM    = 3'd2,
        ST_DIV_R    = 3'd3,
        ST_DIV_B    = 3'd4,
        ST_APPLY    = 3'd5
    } cal_state_e;

    // Gain of 1.0 in unsigned fixed point with frac_w fractional bits.
    function automatic logic [31:0] unity_coef(input int frac_w);
        return 32'd1 << frac_w;
    endfunction

endpackage

// File: rtl/wb_seq_div.sv
// rtl/wb_seq_div.sv - restoring divider, one quotient bit per cycle, saturating quotient
module wb_seq_div #(
    parameter int DIVD_W = 42,
    parameter int DIVS_W = 32,
    parameter int QUO_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIVD_W-1:0] dividend_i,
    input  logic [DIVS_W-1:0] divisor_i,
    output logic              done_o,
    output logic [QUO_W-1:0]  quotient_o
);

    localparam int CNT_W = $clog2(DIVD_W + 1);

    logic [DIVD_W-1:0] quo;
    logic [DIVS_W-1:0] rem;
    logic [DIVS_W-1:0] dvs;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic [DIVS_W:0]   trial;
    logic              fits;
    logic [DIVS_W-1:0] rem_nxt;
    logic [DIVD_W-1:0] quo_nxt;

    function automatic logic [QUO_W-1:0] sat_quo(input logic [DIVD_W-1:0] q);
        return (|q[DIVD_W-1:QUO_W]) ? {QUO_W{1'b1}} : q[QUO_W-1:0];
    endfunction

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    always_comb begin
        trial   = {rem, quo[DIVD_W-1]};
        fits    = (trial >= {1'b0, dvs});
        rem_nxt = fits ? DIVS_W'(trial - {1'b0, dvs}) : trial[DIVS_W-1:0];
        quo_nxt = {quo[DIVD_W-2:0], fits};
    end

    // Iteration control; a new start always restarts, a zero divisor answers all-ones at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done_o     <= 1'b0;
            quotient_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                if (divisor_i == '0) begin
                    quotient_o <= {QUO_W{1'b1}};
                    done_o     <= 1'b1;
                    busy       <= 1'b0;
                end else begin
                    quo  <= dividend_i;
                    rem  <= '0;
                    dvs  <= divisor_i;
                    cnt  <= CNT_W'(DIVD_W);
                    busy <= 1'b1;
                end
            end else if (busy) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy       <= 1'b0;
                    done_o     <= 1'b1;
                    quotient_o <= sat_quo(quo_nxt);
                end
            end
        end
    end

endmodule

// File: rtl/wb_cal_ctrl.sv
// rtl/wb_cal_ctrl.sv - white-balance calibration controller; WB_CAL_CLIP_EXCLUDE_EN skips clipped pixels
module wb_cal_ctrl
    import wb_cal_ctrl_pkg::*;
#(
    parameter int PX_WIDTH   = 10,
    parameter int FRAME_PX_W = 22,
    parameter int FRAC_W     = 10,
    parameter int COEF_W     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          mode_i,
    input  logic                cal_stb_i,
    input  logic [1:0]          man_sel_i,
    input  logic [31:0]         man_coef_i,
    input  logic                man_lock_i,
    input  logic                px_valid_i,
    input  logic                sof_i,
    input  logic [PX_WIDTH-1:0] r_i,
    input  logic [PX_WIDTH-1:0] g_i,
    input  logic [PX_WIDTH-1:0] b_i,
    output logic [COEF_W-1:0]   coef_r_o,
    output logic [COEF_W-1:0]   coef_g_o,
    output logic [COEF_W-1:0]   coef_b_o,
    output logic                coef_upd_o,
    output logic                busy_o,
    output logic [31:0]         cur_coef_o
);

    localparam int SUM_W  = PX_WIDTH + FRAME_PX_W;
    localparam int DIVD_W = SUM_W + FRAC_W;
    localparam logic [COEF_W-1:0] UNITY = COEF_W'(unity_coef(FRAC_W));

    cal_mode_e         mode;
    cal_state_e        state;
    logic              sof;
    logic              px_ok;
    logic              run_ok;
    logic [SUM_W-1:0]  sum_r, sum_g, sum_b;
    logic [COEF_W-1:0] pend_r, pend_b;
    logic [COEF_W-1:0] stage_r, stage_g, stage_b;
    logic              div_start;
    logic              div_done;
    logic [COEF_W-1:0] div_quo;
    logic [SUM_W-1:0]  div_divisor;
    logic [DIVD_W-1:0] div_dividend;
    logic              unused_coef_hi;

    assign mode           = cal_mode_e'(mode_i);
    assign sof            = px_valid_i && sof_i;
    assign run_ok         = (mode == MODE_AUTO) || (mode == MODE_ONESHOT);
    assign busy_o         = (state != ST_IDLE);
    assign unused_coef_hi = ^man_coef_i[31:COEF_W];

`ifdef WB_CAL_CLIP_EXCLUDE_EN
    assign px_ok = !((r_i == '1) || (g_i == '1) || (b_i == '1));
`else
    assign px_ok = 1'b1;
`endif

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s, input logic [PX_WIDTH-1:0] p);
        logic [SUM_W:0] t;
        t = {1'b0, s} + (SUM_W + 1)'(p);
        return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
    endfunction

    // R and B gains share one divider; the state picks which channel is the divisor.
    assign div_divisor  = (state == ST_DIV_B) ? sum_b : sum_r;
    assign div_dividend = {sum_g, {FRAC_W{1'b0}}};

    wb_seq_div #(
        .DIVD_W(DIVD_W),
        .DIVS_W(SUM_W),
        .QUO_W (COEF_W)
    ) u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (div_start),
        .dividend_i(div_dividend),
        .divisor_i (div_divisor),
        .done_o    (div_done),
        .quotient_o(div_quo)
    );

    // Manual/bypass coefficient paths plus the calibration FSM; active gains move only on sof.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            sum_r      <= '0;
            sum_g      <= '0;
            sum_b      <= '0;
            coef_r_o   <= UNITY;
            coef_g_o   <= UNITY;
            coef_b_o   <= UNITY;
            pend_r     <= UNITY;
            pend_b     <= UNITY;
            stage_r    <= UNITY;
            stage_g    <= UNITY;
            stage_b    <= UNITY;
            coef_upd_o <= 1'b0;
            div_start  <= 1'b0;
        end else begin
            coef_upd_o <= 1'b0;
            div_start  <= 1'b0;

            if (mode == MODE_MANUAL && !man_lock_i) begin
                case (man_sel_i)
                    2'd0:    stage_r <= man_coef_i[COEF_W-1:0];
                    2'd1:    stage_g <= man_coef_i[COEF_W-1:0];
                    2'd2:    stage_b <= man_coef_i[COEF_W-1:0];
                    default: ;
                endcase
            end

            if (sof && mode == MODE_MANUAL) begin
                coef_r_o   <= stage_r;
                coef_g_o   <= stage_g;
                coef_b_o   <= stage_b;
                coef_upd_o <= 1'b1;
            end else if (sof && mode == MODE_BYPASS) begin
                coef_r_o   <= UNITY;
                coef_g_o   <= UNITY;
                coef_b_o   <= UNITY;
                coef_upd_o <= 1'b1;
            end

            if (state != ST_IDLE && !run_ok) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (mode == MODE_AUTO || (mode == MODE_ONESHOT && cal_stb_i))
                            state <= ST_WAIT_SOF;
                    end
                    ST_WAIT_SOF: begin
                        if (sof) begin
                            sum_r <= px_ok ? SUM_W'(r_i) : '0;
                            sum_g <= px_ok ? SUM_W'(g_i) : '0;
                            sum_b <= px_ok ? SUM_W'(b_i) : '0;
                            state <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        if (sof) begin
                            state     <= ST_DIV_R;
                            div_start <= 1'b1;
                        end else if (px_valid_i && px_ok) begin
                            sum_r <= sat_add(sum_r, r_i);
                            sum_g <= sat_add(sum_g, g_i);
                            sum_b <= sat_add(sum_b, b_i);
                        end
                    end
                    ST_DIV_R: begin
                        if (div_done && !div_start) begin
                            pend_r    <= div_quo;
                            state     <= ST_DIV_B;
                            div_start <= 1'b1;
                        end
                    end
                    ST_DIV_B: begin
                        if (div_done && !div_start) begin
                            pend_b <= div_quo;
                            state  <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        if (sof) begin
                            coef_r_o   <= pend_r;
                            coef_g_o   <= UNITY;
                            coef_b_o   <= pend_b;
                            coef_upd_o <= 1'b1;
                            if (mode == MODE_AUTO) begin
                                sum_r <= px_ok ? SUM_W'(r_i) : '0;
                                sum_g <= px_ok ? SUM_W'(g_i) : '0;
                                sum_b <= px_ok ? SUM_W'(b_i) : '0;
                                state <= ST_ACCUM;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Read-back of the active gain for the selected channel.
    always_comb begin
        cur_coef_o = 32'd0;
        case (man_sel_i)
            2'd0:    cur_coef_o = 32'(coef_r_o);
            2'd1:    cur_coef_o = 32'(coef_g_o);
            2'd2:    cur_coef_o = 32'(coef_b_o);
            default: cur_coef_o = 32'd0;
        endcase
    end

endmodule
